// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS CPU fetch/execute sequencer.
//   cpu_state_e : sequencer state (FETCH, EXEC, HALTED)
//   npc_sel_e   : next-PC source chosen at execute completion
//   pc_plus4    : sequential PC increment, wraps modulo 2^32
package mips_cpu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] RESET_VECTOR_DFLT = 32'hBFC0_0000;
  localparam logic [ADDR_W-1:0] HALT_ADDR_DFLT    = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } cpu_state_e;

  typedef enum logic {
    NPC_SEQ    = 1'b0,
    NPC_TARGET = 1'b1
  } npc_sel_e;

  function automatic logic [ADDR_W-1:0] pc_plus4(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(4);
  endfunction

endpackage

// File: rtl/mips_cpu_pc_sequencer_if.sv
// Instruction-fetch bus plus execute-stage handshake of the PC sequencer.
//   master : sequencer side (drives address/read, instr/instr_valid, cur_pc, active, fault)
//   slave  : memory/execute side (drives waitrequest/readdata, exec_stall, branch_*)
interface mips_cpu_pc_sequencer_if;
  import mips_cpu_pkg::*;

  logic               waitrequest;
  logic [INSTR_W-1:0] readdata;
  logic [ADDR_W-1:0]  address;
  logic               read;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               exec_stall;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic [ADDR_W-1:0]  cur_pc;
  logic               active;
  logic               fault;

  modport master (
    input  waitrequest, readdata, exec_stall, branch_taken, branch_target,
    output address, read, instr, instr_valid, cur_pc, active, fault
  );

  modport slave (
    output waitrequest, readdata, exec_stall, branch_taken, branch_target,
    input  address, read, instr, instr_valid, cur_pc, active, fault
  );

endinterface

// File: rtl/mips_cpu_delay_slot_tracker.sv
// Tracks a taken branch across its single delay slot and selects the next PC.
//   complete      : execute stage finished the current instruction this cycle
//   branch_taken  : current instruction redirects control (sampled on complete)
//   branch_target : redirect target
//   npc_sel_c     : NPC_TARGET when the retiring instruction is a delay slot
//   saved_target  : target recorded by the branch that opened the delay slot
//   misaligned_c  : an accepted branch carries a non-word-aligned target
//   halt_c        : the pending target is the halt address
module mips_cpu_delay_slot_tracker
  import mips_cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] HALT_ADDR = HALT_ADDR_DFLT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              complete,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output npc_sel_e          npc_sel_c,
  output logic [ADDR_W-1:0] saved_target,
  output logic              misaligned_c,
  output logic              halt_c
);

  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] saved_target_q, saved_target_d;
  logic              accept_c;

  // A branch inside a delay slot is ignored, so alignment only matters
  // for a branch that would actually open a new delay slot.
  always_comb begin
    accept_c       = !pending_q && branch_taken && (branch_target[1:0] == 2'b00);
    misaligned_c   = !pending_q && branch_taken && (branch_target[1:0] != 2'b00);
    halt_c         = pending_q && (saved_target_q == HALT_ADDR);
    npc_sel_c      = pending_q ? NPC_TARGET : NPC_SEQ;
    pending_d      = pending_q;
    saved_target_d = saved_target_q;
    if (complete) begin
      if (pending_q) begin
        pending_d = 1'b0;
      end else if (accept_c) begin
        pending_d      = 1'b1;
        saved_target_d = branch_target;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q      <= 1'b0;
      saved_target_q <= '0;
    end else begin
      pending_q      <= pending_d;
      saved_target_q <= saved_target_d;
    end
  end

  assign saved_target = saved_target_q;

endmodule

// File: rtl/mips_cpu_pc_sequencer.sv
// Multicycle fetch/execute sequencer owning the MIPS program counter.
//   clk, reset_n : clock and asynchronous active-low reset
//   bus (master) : Avalon-style instruction read (address/read out,
//                  waitrequest/readdata in), execute handshake (instr,
//                  instr_valid, exec_stall, branch_taken/target, cur_pc)
//                  and status (active, fault)
module mips_cpu_pc_sequencer
  import mips_cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DFLT,
  parameter logic [ADDR_W-1:0] HALT_ADDR    = HALT_ADDR_DFLT
) (
  input  logic                    clk,
  input  logic                    reset_n,
  mips_cpu_pc_sequencer_if.master bus
);

  cpu_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               read_q, read_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;
  logic               active_q, active_d;
  logic               fault_q, fault_d;

  logic               complete_c;
  npc_sel_e           npc_sel_c;
  logic [ADDR_W-1:0]  saved_target;
  logic               misaligned_c;
  logic               halt_c;

  assign complete_c = (state_q == EXEC) && !bus.exec_stall;

  mips_cpu_delay_slot_tracker #(
    .HALT_ADDR (HALT_ADDR)
  ) u_delay_slot (
    .clk           (clk),
    .reset_n       (reset_n),
    .complete      (complete_c),
    .branch_taken  (bus.branch_taken),
    .branch_target (bus.branch_target),
    .npc_sel_c     (npc_sel_c),
    .saved_target  (saved_target),
    .misaligned_c  (misaligned_c),
    .halt_c        (halt_c)
  );

  // Next state, next PC and registered bus/status outputs.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    read_d        = 1'b0;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    active_d      = active_q;
    fault_d       = fault_q;
    case (state_q)
      FETCH: begin
        // Capture only once the request has been visible on the bus.
        if (read_q && !bus.waitrequest) begin
          instr_d       = bus.readdata;
          instr_valid_d = 1'b1;
          state_d       = EXEC;
        end else begin
          read_d = 1'b1;
        end
      end
      EXEC: begin
        if (complete_c) begin
          if (misaligned_c) begin
            fault_d  = 1'b1;
            active_d = 1'b0;
            state_d  = HALTED;
          end else begin
            pc_d = (npc_sel_c == NPC_TARGET) ? saved_target : pc_plus4(pc_q);
            if (halt_c) begin
              active_d = 1'b0;
              state_d  = HALTED;
            end else begin
              read_d  = 1'b1;
              state_d = FETCH;
            end
          end
        end
      end
      HALTED: begin
        active_d = 1'b0;
      end
      default: begin
        active_d = 1'b0;
        state_d  = HALTED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_VECTOR;
      read_q        <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      active_q      <= 1'b1;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      read_q        <= read_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      active_q      <= active_d;
      fault_q       <= fault_d;
    end
  end

  assign bus.address     = pc_q;
  assign bus.read        = read_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.cur_pc      = pc_q;
  assign bus.active      = active_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_mips_cpu_pc_sequencer.sv
// Self-checking bench for mips_cpu_pc_sequencer: directed scenarios plus a
// randomized program checked against an architectural next-PC model.
module tb_mips_cpu_pc_sequencer;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  mips_cpu_pc_sequencer_if bus ();

  mips_cpu_pc_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural model: only PC, one pending target, halt/fault flags.
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  logic        m_pend;
  logic        m_halt;
  logic        m_fault;

  task automatic model_reset();
    m_pc = RV; m_tgt = '0; m_pend = 1'b0; m_halt = 1'b0; m_fault = 1'b0;
  endtask

  task automatic model_step(input logic br, input logic [31:0] tgt);
    if (m_pend) begin
      m_pend = 1'b0;
      m_pc   = m_tgt;
      if (m_tgt == 32'h0) m_halt = 1'b1;
    end else if (br && (tgt % 4 != 0)) begin
      m_fault = 1'b1;
      m_halt  = 1'b1;
    end else begin
      if (br) begin
        m_pend = 1'b1;
        m_tgt  = tgt;
      end
      m_pc = m_pc + 32'd4;
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h3C08_A5A5;
  endfunction

  task automatic do_reset();
    reset_n           = 1'b0;
    bus.waitrequest   = 1'b0;
    bus.readdata      = '0;
    bus.exec_stall    = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // Serves one fetch (with nwait wait-states) and executes it (nstall stall
  // cycles carrying junk branch inputs), then completes with br/tgt.
  task automatic exec_one(input int nwait, input int nstall, input logic br,
                          input logic [31:0] tgt, output logic [31:0] f_addr,
                          output logic [31:0] f_instr, output logic [31:0] f_cur,
                          output logic f_valid, output logic f_valid2,
                          output logic stable, output logic to);
    int cnt;
    cnt = 0; to = 1'b0; stable = 1'b1;
    f_addr = 'x; f_instr = 'x; f_cur = 'x; f_valid = 1'b0; f_valid2 = 1'b1;
    while (bus.read !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (bus.read !== 1'b1) begin
      to = 1'b1;
      return;
    end
    f_addr = bus.address;
    for (int k = 0; k < nwait; k++) begin
      bus.waitrequest = 1'b1;
      bus.readdata    = $urandom;
      @(negedge clk);
      if (bus.read !== 1'b1 || bus.address !== f_addr) stable = 1'b0;
    end
    bus.waitrequest = 1'b0;
    bus.readdata    = instr_of(f_addr);
    @(negedge clk);
    bus.readdata = $urandom;
    f_instr = bus.instr;
    f_valid = bus.instr_valid;
    f_cur   = bus.cur_pc;
    for (int k = 0; k < nstall; k++) begin
      bus.exec_stall    = 1'b1;
      bus.branch_taken  = 1'b1;
      bus.branch_target = $urandom;
      @(negedge clk);
    end
    bus.exec_stall    = 1'b0;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    @(negedge clk);
    f_valid2          = bus.instr_valid;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
  endtask

  logic [31:0] a, ins, cur;
  logic        v, v2, st, to;

  task automatic test_reset();
    reset_n = 1'b0;
    bus.waitrequest = 1'b1; bus.readdata = 32'hDEAD_BEEF;
    bus.exec_stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
    repeat (2) @(negedge clk);
    n_tests++; if (bus.read !== 1'b0) begin n_fail++; $display("FAIL reset_read: got %b want 0", bus.read); end
    n_tests++; if (bus.address !== RV) begin n_fail++; $display("FAIL reset_addr: got %h want %h", bus.address, RV); end
    n_tests++; if (bus.instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", bus.instr); end
    n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
    n_tests++; if (bus.active !== 1'b1) begin n_fail++; $display("FAIL reset_active: got %b want 1", bus.active); end
    n_tests++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", bus.fault); end
    // Reset asserted while a fetch is outstanding must drop read at once.
    reset_n = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.read !== 1'b1) begin n_fail++; $display("FAIL fetch_start_read: got %b want 1", bus.read); end
    bus.waitrequest = 1'b0;
    reset_n = 1'b0;
    #1;
    n_tests++; if (bus.read !== 1'b0) begin n_fail++; $display("FAIL reset_abort_read: got %b want 0", bus.read); end
    @(negedge clk);
    n_tests++; if (bus.instr !== 32'h0) begin n_fail++; $display("FAIL reset_abort_instr: got %h want 0", bus.instr); end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exec_one(0, 0, 1'b0, 32'h0, a, ins, cur, v, v2, st, to);
      n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL seq_timeout[%0d]: got %b want 0", i, to); end
      n_tests++; if (a !== RV + 32'(4 * i)) begin n_fail++; $display("FAIL seq_addr[%0d]: got %h want %h", i, a, RV + 32'(4 * i)); end
      n_tests++; if (ins !== instr_of(RV + 32'(4 * i))) begin n_fail++; $display("FAIL seq_instr[%0d]: got %h want %h", i, ins, instr_of(RV + 32'(4 * i))); end
      n_tests++; if ({v, v2} !== 2'b10) begin n_fail++; $display("FAIL seq_valid_pulse[%0d]: got %b want 10", i, {v, v2}); end
      n_tests++; if (bus.active !== 1'b1) begin n_fail++; $display("FAIL seq_active[%0d]: got %b want 1", i, bus.active); end
    end
  endtask

  task automatic test_waitrequest();
    do_reset();
    exec_one(3, 0, 1'b0, 32'h0, a, ins, cur, v, v2, st, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL wait_timeout: got %b want 0", to); end
    n_tests++; if (st !== 1'b1) begin n_fail++; $display("FAIL wait_stable: got %b want 1", st); end
    n_tests++; if (a !== RV) begin n_fail++; $display("FAIL wait_addr: got %h want %h", a, RV); end
    n_tests++; if (ins !== instr_of(RV)) begin n_fail++; $display("FAIL wait_instr: got %h want %h", ins, instr_of(RV)); end
    n_tests++; if (v !== 1'b1) begin n_fail++; $display("FAIL wait_valid: got %b want 1", v); end
  endtask

  task automatic test_branch();
    logic [31:0] exp_a [5] = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008, 32'hBFC0_0100, 32'hBFC0_0104};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exec_one(1, 1, (i == 1), 32'hBFC0_0100, a, ins, cur, v, v2, st, to);
      n_tests++; if (a !== exp_a[i]) begin n_fail++; $display("FAIL branch_addr[%0d]: got %h want %h", i, a, exp_a[i]); end
      n_tests++; if (cur !== exp_a[i]) begin n_fail++; $display("FAIL branch_cur_pc[%0d]: got %h want %h", i, cur, exp_a[i]); end
    end
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      exec_one(0, (i % 2), (i == 4), 32'h0, a, ins, cur, v, v2, st, to);
      n_tests++; if (a !== RV + 32'(4 * i)) begin n_fail++; $display("FAIL halt_addr[%0d]: got %h want %h", i, a, RV + 32'(4 * i)); end
    end
    for (int c = 0; c < 4; c++) begin
      n_tests++; if ({bus.active, bus.read, bus.instr_valid} !== 3'b000) begin n_fail++; $display("FAIL halt_idle[%0d]: active/read/valid got %b want 000", c, {bus.active, bus.read, bus.instr_valid}); end
      @(negedge clk);
    end
  endtask

  task automatic test_delay_slot_branch();
    logic [31:0] exp_a [5] = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0200, 32'hBFC0_0204, 32'hBFC0_0208};
    logic [31:0] tg [5]    = '{32'hBFC0_0200, 32'hBFC0_0300, 32'h0, 32'h0, 32'h0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exec_one(0, 0, (i < 2), tg[i], a, ins, cur, v, v2, st, to);
      n_tests++; if (a !== exp_a[i]) begin n_fail++; $display("FAIL ds_branch_addr[%0d]: got %h want %h", i, a, exp_a[i]); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [6] = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      exec_one(0, 0, (i == 0), 32'hFFFF_FFF8, a, ins, cur, v, v2, st, to);
      n_tests++; if (a !== exp_a[i]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, a, exp_a[i]); end
    end
    n_tests++; if (bus.active !== 1'b1) begin n_fail++; $display("FAIL wrap_active: got %b want 1", bus.active); end
  endtask

  task automatic test_fault();
    do_reset();
    exec_one(0, 0, 1'b1, 32'hBFC0_0102, a, ins, cur, v, v2, st, to);
    for (int c = 0; c < 4; c++) begin
      n_tests++; if ({bus.fault, bus.active, bus.read} !== 3'b100) begin n_fail++; $display("FAIL fault_state[%0d]: fault/active/read got %b want 100", c, {bus.fault, bus.active, bus.read}); end
      @(negedge clk);
    end
    do_reset();
    n_tests++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL fault_cleared: got %b want 0", bus.fault); end
    exec_one(0, 0, 1'b0, 32'h0, a, ins, cur, v, v2, st, to);
    n_tests++; if (a !== RV) begin n_fail++; $display("FAIL fault_restart_addr: got %h want %h", a, RV); end
  endtask

  task automatic test_random();
    logic        br;
    logic [31:0] tgt;
    int          r;
    do_reset();
    for (int i = 0; i < 120; i++) begin
      br  = ($urandom_range(0, 3) == 0);
      r   = $urandom_range(0, 11);
      tgt = RV + 32'($urandom_range(0, 63) * 4);
      if (r == 0) tgt = 32'h0;
      else if (r == 1) tgt = tgt | 32'($urandom_range(1, 3));
      exec_one($urandom_range(0, 2), $urandom_range(0, 2), br, tgt, a, ins, cur, v, v2, st, to);
      n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL rnd_timeout[%0d]: got %b want 0", i, to); end
      n_tests++; if (a !== m_pc || cur !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: addr %h cur_pc %h want %h", i, a, cur, m_pc); end
      n_tests++; if (ins !== instr_of(m_pc) || v !== 1'b1) begin n_fail++; $display("FAIL rnd_instr[%0d]: got %h/%b want %h/1", i, ins, v, instr_of(m_pc)); end
      model_step(br, tgt);
      n_tests++; if ({bus.active, bus.fault} !== {~m_halt, m_fault}) begin n_fail++; $display("FAIL rnd_status[%0d]: active/fault got %b want %b", i, {bus.active, bus.fault}, {~m_halt, m_fault}); end
      if (m_halt) begin
        @(negedge clk);
        n_tests++; if (bus.read !== 1'b0) begin n_fail++; $display("FAIL rnd_halt_read[%0d]: got %b want 0", i, bus.read); end
        do_reset();
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    test_reset();
    test_sequential();
    test_waitrequest();
    test_branch();
    test_halt();
    test_delay_slot_branch();
    test_wrap();
    test_fault();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_cpu_pc_sequencer.md
Name: mips_cpu_pc_sequencer

Overview:
- Multicycle fetch/execute sequencer that owns the program counter for the MIPS CPU.
- Drives the Avalon-style instruction read: address/read out, waitrequest/readdata in.
- Hands each fetched instruction to the execute stage and resolves branches/jumps with one architectural delay slot.
- Detects the halt condition (jump to address 0) and holds the CPU idle.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.
- HALT_ADDR, 32'h00000000, target address that terminates execution once its delay slot retires.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- waitrequest  in  1  memory not ready; hold read/address stable while high
- readdata  in  32  instruction word from memory
- address  out  32  instruction fetch address (= pc)
- read  out  1  fetch request
- instr  out  32  latched instruction for execute stage
- instr_valid  out  1  one-cycle pulse: instr valid, execute may begin
- exec_stall  in  1  execute stage busy (mult/div, data-memory wait); hold in EXEC
- branch_taken  in  1  sampled on the exec-complete cycle: current instr redirects control
- branch_target  in  32  redirect target, valid with branch_taken
- cur_pc  out  32  PC of instruction in execute (for link/branch offset arithmetic)
- active  out  1  high while CPU running, low after halt
- fault  out  1  sticky: misaligned branch target seen

Behaviour:
- Async reset (reset_n=0): pc=RESET_VECTOR, state=FETCH, pending=0, read=0, instr=0, instr_valid=0, active=1, fault=0. Reset mid-fetch aborts the read immediately; no readdata is captured.
- States: FETCH, EXEC, HALTED.
- FETCH:
  - read=1, address=pc.
  - While waitrequest=1: stay; address constant.
  - On waitrequest=0: instr<=readdata, pulse instr_valid next cycle, go to EXEC.
  - Minimum fetch latency: 1 cycle from entry to capture.
- EXEC:
  - read=0; cur_pc=pc.
  - While exec_stall=1: stay; branch inputs ignored.
  - Complete on exec_stall=0. Next-PC rules at completion:
    - pending=1 (this instr is a delay slot): pc<=saved_target, pending<=0. If saved_target==HALT_ADDR, go to HALTED instead of FETCH.
    - pending=0 and branch_taken=1: saved_target<=branch_target, pending<=1, pc<=pc+4. The delay slot is fetched next.
    - Otherwise: pc<=pc+4.
    - A branch_taken inside a delay slot is ignored; the original pending target wins.
  - pc+4 is a 32-bit add; it wraps 32'hFFFFFFFC -> 0 with no flag.
- Misaligned target (branch_target[1:0]!=0 with branch_taken=1 at completion): fault<=1, go to HALTED, active<=0.
- HALTED: read=0, instr_valid=0, active=0, pc frozen; exit only via reset.
- active is registered and drops on the cycle the state becomes HALTED.
- instr holds its value outside capture.

Decomposition:
- Shared package mips_cpu_pkg:
  - state enum (FETCH, EXEC, HALTED)
  - RESET_VECTOR/HALT_ADDR constants
  - INSTR_W=32
- One natural sub-module: mips_cpu_delay_slot_tracker. It holds pending and saved_target and outputs the next-PC select.
- The FSM, pc register and bus outputs stay in the top module.

Test Plan:
- Reset release with waitrequest=0, exec_stall=0, no branches -> address sequence BFC00000, BFC00004, BFC00008; active=1, one instr_valid per instruction.
- waitrequest held high 3 cycles in FETCH -> read=1 and address=BFC00000 stable for 4 cycles; instr captures readdata only on the low cycle.
- Branch at BFC00004 with target BFC00100 -> next fetches BFC00008 (delay slot), then BFC00100; cur_pc matches each.
- Jump to 0 at BFC00010 -> delay slot BFC00014 executes, then HALTED: active=0, read=0 from the next cycle onward.
- Branch in delay slot (first target BFC00200, second BFC00300) -> fetch goes to BFC00200; no later fetch of BFC00300.
- branch_target=BFC00102 -> fault=1, active=0, no further reads. Then reset_n pulse -> fault=0, fetch restarts at BFC00000.
